// File: rtl/sseg_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : sseg_pkg
// Description : Shared types and segment codes for the seven-segment scanner.
// Revision    : 1.0
// ============================================================================
package sseg_pkg;

    localparam int REFRESH_DIV_DEFAULT = 100000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CONV   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    // Active-low {dp,g,f,e,d,c,b,a}; dp is off in every code.
    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_MINUS = 8'hBF;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    function automatic logic [3:0] dd_adj(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_to_sseg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : bcd_to_sseg
// Description : Combinational BCD digit to active-low 7-segment mapping.
// Revision    : 1.0
// ============================================================================
module bcd_to_sseg
    import sseg_pkg::*;
(
    input  logic [3:0] i_code,
    input  logic       i_blank,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK[6:0];
        if (!i_blank) begin
            case (i_code)
                4'd0:    o_seg = SEG_0[6:0];
                4'd1:    o_seg = SEG_1[6:0];
                4'd2:    o_seg = SEG_2[6:0];
                4'd3:    o_seg = SEG_3[6:0];
                4'd4:    o_seg = SEG_4[6:0];
                4'd5:    o_seg = SEG_5[6:0];
                4'd6:    o_seg = SEG_6[6:0];
                4'd7:    o_seg = SEG_7[6:0];
                4'd8:    o_seg = SEG_8[6:0];
                4'd9:    o_seg = SEG_9[6:0];
                default: o_seg = SEG_BLANK[6:0];
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/sseg_scan_driver.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : sseg_scan_driver
// Description : Binary to BCD conversion plus 4-digit multiplexed display scan.
// Revision    : 1.0
// ============================================================================
module sseg_scan_driver
    import sseg_pkg::*;
#(
    parameter int REFRESH_DIV = REFRESH_DIV_DEFAULT
)(
    input  logic       clk,
    input  logic       clr,
    input  logic       en,
    input  logic [7:0] din,
    input  logic       signed_mode,
    input  logic       err,
    input  logic       load,
    output logic       busy,
    output logic [7:0] sseg,
    output logic [3:0] an
);

    localparam int             PW   = $clog2(REFRESH_DIV);
    localparam logic [PW-1:0]  PMAX = PW'(REFRESH_DIV - 1);

    state_t        r_state;
    logic          r_busy;
    logic [3:0]    r_cnt;
    logic [7:0]    r_mag;
    logic [7:0]    r_shift;
    logic          r_sign;
    logic          r_err;
    logic [3:0]    r_h, r_t, r_o;
    logic [3:0]    r_dh, r_dt, r_do;
    logic          r_dsign, r_derr, r_dvalid;
    logic [PW-1:0] r_presc;
    logic [1:0]    r_idx;
    logic [3:0]    r_an;
    logic [7:0]    r_sseg;

    logic          w_neg;
    logic [7:0]    w_mag;
    logic [19:0]   w_dd;
    logic [3:0]    w_code;
    logic          w_blank;
    logic          w_dp;
    logic [6:0]    w_seg7;
    logic [7:0]    w_seg;

    assign w_neg = signed_mode & din[7];
    assign w_mag = w_neg ? (~din + 8'd1) : din;
    assign w_dd  = {dd_adj(r_h), dd_adj(r_t), dd_adj(r_o), r_shift} << 1;

    // The first CONV cycle seeds the shifter; the remaining eight shift-add-3.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state  <= ST_IDLE;
            r_busy   <= 1'b0;
            r_cnt    <= 4'd0;
            r_mag    <= 8'd0;
            r_shift  <= 8'd0;
            r_sign   <= 1'b0;
            r_err    <= 1'b0;
            r_h      <= 4'd0;
            r_t      <= 4'd0;
            r_o      <= 4'd0;
            r_dh     <= 4'd0;
            r_dt     <= 4'd0;
            r_do     <= 4'd0;
            r_dsign  <= 1'b0;
            r_derr   <= 1'b0;
            r_dvalid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (load) begin
                        r_mag   <= w_mag;
                        r_sign  <= w_neg;
                        r_err   <= err;
                        r_cnt   <= 4'd0;
                        r_busy  <= 1'b1;
                        r_state <= ST_CONV;
                    end
                end
                ST_CONV: begin
                    if (r_cnt == 4'd0) begin
                        r_shift <= r_mag;
                        r_h     <= 4'd0;
                        r_t     <= 4'd0;
                        r_o     <= 4'd0;
                        r_cnt   <= 4'd1;
                    end else begin
                        {r_h, r_t, r_o, r_shift} <= w_dd;
                        if (r_cnt == 4'd8) begin
                            r_state <= ST_COMMIT;
                        end else begin
                            r_cnt <= r_cnt + 4'd1;
                        end
                    end
                end
                ST_COMMIT: begin
                    r_dh     <= r_h;
                    r_dt     <= r_t;
                    r_do     <= r_o;
                    r_dsign  <= r_sign;
                    r_derr   <= r_err;
                    r_dvalid <= 1'b1;
                    r_busy   <= 1'b0;
                    r_state  <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        w_code  = r_do;
        w_blank = !r_dvalid;
        w_dp    = 1'b1;
        case (r_idx)
            2'd0: begin
                w_code = r_do;
                w_dp   = ~r_derr;
            end
            2'd1: begin
                w_code  = r_dt;
                w_blank = !r_dvalid || ((r_dh == 4'd0) && (r_dt == 4'd0));
            end
            2'd2: begin
                w_code  = r_dh;
                w_blank = !r_dvalid || (r_dh == 4'd0);
            end
            default: begin
                w_code  = 4'd0;
                w_blank = 1'b1;
            end
        endcase
    end

    bcd_to_sseg u_dec (
        .i_code  (w_code),
        .i_blank (w_blank),
        .o_seg   (w_seg7)
    );

    assign w_seg = (r_idx == 2'd3) ? (r_dsign ? SEG_MINUS : SEG_BLANK)
                                   : {w_dp, w_seg7};

    // an and sseg are both sampled from the same r_idx, so they stay aligned.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_presc <= '0;
            r_idx   <= 2'd0;
            r_an    <= 4'hF;
            r_sseg  <= SEG_BLANK;
        end else if (en) begin
            if (r_presc == PMAX) begin
                r_presc <= '0;
                r_idx   <= r_idx + 2'd1;
            end else begin
                r_presc <= r_presc + PW'(1);
            end
            r_an   <= ~(4'b0001 << r_idx);
            r_sseg <= w_seg;
        end else begin
            r_an   <= 4'hF;
            r_sseg <= SEG_BLANK;
        end
    end

    assign busy = r_busy;
    assign sseg = r_sseg;
    assign an   = r_an;

endmodule
`default_nettype wire

// File: tb/tb_sseg_scan_driver.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_sseg_scan_driver
// Description : Self-checking bench for sseg_scan_driver with REFRESH_DIV=4.
// Revision    : 1.0
// ============================================================================
module tb_sseg_scan_driver;

    logic       clk = 1'b0;
    logic       clr, en, signed_mode, err, load, busy;
    logic [7:0] din, sseg;
    logic [3:0] an;
    int         total = 0;
    int         bad   = 0;

    always #5 clk = ~clk;

    sseg_scan_driver #(.REFRESH_DIV(4)) dut (
        .clk         (clk),
        .clr         (clr),
        .en          (en),
        .din         (din),
        .signed_mode (signed_mode),
        .err         (err),
        .load        (load),
        .busy        (busy),
        .sseg        (sseg),
        .an          (an)
    );

    typedef struct {
        logic       sm;
        logic [7:0] d;
        logic       er;
        logic [7:0] d3, d2, d1, d0;
        string      nm;
    } vec_t;

    typedef struct {
        logic [3:0] an;
        logic [7:0] sseg;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic push_scan(input logic [7:0] d3, d2, d1, d0);
        logic [7:0] ds[4];
        logic [3:0] m;
        exp_t       e;
        ds[0] = d0; ds[1] = d1; ds[2] = d2; ds[3] = d3;
        for (int k = 0; k < 4; k++) begin
            m = 4'b0001 << k;
            for (int c = 0; c < 4; c++) begin
                e.an   = ~m;
                e.sseg = ds[k];
                sb.push_back(e);
            end
        end
    endtask

    task automatic convert(input logic sm, input logic [7:0] d, input logic er, input string nm);
        int n;
        signed_mode = sm; din = d; err = er; load = 1'b1;
        tick();
        load = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 50) begin
            tick();
            n++;
        end
        chk({nm, " busy_cycles"}, n, 10);
    endtask

    task automatic wait_an(input logic [3:0] target, output bit found);
        logic [3:0] prev;
        prev  = an;
        found = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (an === target && prev !== target) begin
                found = 1;
                break;
            end
            prev = an;
        end
    endtask

    task automatic drain_scan(input string nm);
        bit   found;
        exp_t e;
        wait_an(4'b1110, found);
        if (!found) begin
            chk({nm, " scan_sync"}, 0, 1);
            sb.delete();
        end
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk({nm, " an"}, an, e.an);
            chk({nm, " sseg"}, sseg, e.sseg);
            if (sb.size() > 0) tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit found;
        int n;
        int scanned;

        vecs[0] = '{1'b1, 8'hF6, 1'b0, 8'hBF, 8'hFF, 8'hF9, 8'hC0, "neg10"};
        vecs[1] = '{1'b0, 8'hFF, 1'b1, 8'hFF, 8'hA4, 8'h92, 8'h12, "u255err"};
        vecs[2] = '{1'b0, 8'h00, 1'b0, 8'hFF, 8'hFF, 8'hFF, 8'hC0, "zero"};
        vecs[3] = '{1'b0, 8'h07, 1'b0, 8'hFF, 8'hFF, 8'hFF, 8'hF8, "seven"};
        vecs[4] = '{1'b0, 8'h64, 1'b0, 8'hFF, 8'hF9, 8'hC0, 8'hC0, "u100"};
        vecs[5] = '{1'b1, 8'h7F, 1'b0, 8'hFF, 8'hF9, 8'hA4, 8'hF8, "s127"};
        vecs[6] = '{1'b0, 8'h80, 1'b0, 8'hFF, 8'hF9, 8'hA4, 8'h80, "u128"};
        vecs[7] = '{1'b1, 8'h9C, 1'b1, 8'hBF, 8'hF9, 8'hC0, 8'h40, "neg100err"};

        clr = 1'b1; en = 1'b1; signed_mode = 1'b0; err = 1'b0; load = 1'b0; din = 8'h00;
        #2 clr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("reset an", an, 4'hF);
            chk("reset sseg", sseg, 8'hFF);
            chk("reset busy", busy, 1'b0);
        end
        clr = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("precommit sseg", sseg, 8'hFF);
        end

        foreach (vecs[i]) begin
            push_scan(vecs[i].d3, vecs[i].d2, vecs[i].d1, vecs[i].d0);
            convert(vecs[i].sm, vecs[i].d, vecs[i].er, vecs[i].nm);
            drain_scan(vecs[i].nm);
        end

        // second load arrives while busy and must be dropped
        push_scan(8'hBF, 8'hF9, 8'hA4, 8'h80);
        signed_mode = 1'b1; din = 8'h80; err = 1'b0; load = 1'b1;
        tick();
        load = 1'b0;
        tick();
        signed_mode = 1'b0; din = 8'h01; load = 1'b1;
        tick();
        load = 1'b0;
        n = 2;
        while (busy === 1'b1 && n < 50) begin
            tick();
            n++;
        end
        chk("ldbusy busy_cycles", n, 10);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("ldbusy no_requeue", busy, 1'b0);
        end
        drain_scan("smin");

        // disable mid-dwell, convert while dark, resume on the same digit
        wait_an(4'b1101, found);
        chk("en sync", found, 1'b1);
        tick();
        en = 1'b0;
        tick();
        chk("en_off an", an, 4'hF);
        chk("en_off sseg", sseg, 8'hFF);
        push_scan(8'hFF, 8'hFF, 8'h99, 8'hA4);
        convert(1'b0, 8'd42, 1'b0, "dark42");
        chk("en_off an after conv", an, 4'hF);
        chk("en_off sseg after conv", sseg, 8'hFF);
        en = 1'b1;
        tick();
        chk("resume an0", an, 4'b1101);
        chk("resume sseg0", sseg, 8'h99);
        tick();
        chk("resume an1", an, 4'b1101);
        tick();
        chk("resume an2", an, 4'b1011);
        drain_scan("dark42");

        // clr pulse during CONV aborts without commit
        signed_mode = 1'b0; din = 8'd99; err = 1'b0; load = 1'b1;
        tick();
        load = 1'b0;
        repeat (5) tick();
        chk("abort busy_before", busy, 1'b1);
        clr = 1'b0;
        #1;
        chk("abort busy", busy, 1'b0);
        chk("abort an", an, 4'hF);
        chk("abort sseg", sseg, 8'hFF);
        tick();
        clr = 1'b1;
        scanned = 0;
        for (int i = 0; i < 24; i++) begin
            tick();
            chk("abort blank sseg", sseg, 8'hFF);
            if (an !== 4'hF) scanned++;
        end
        chk("abort busy_after", busy, 1'b0);
        chk("abort scan_running", (scanned > 0), 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sseg_scan_driver.md
SSEG_SCAN_DRIVER -- requirements
Module: sseg_scan_driver

Interface
REQ-001 Parameter REFRESH_DIV, 100000, clk cycles per digit dwell (1 kHz per digit at 100 MHz); legal range 2 or greater.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 clr  input  1  asynchronous, active-low reset.
REQ-004 en  input  1  display enable; low blanks all digits.
REQ-005 din  input  8  binary value from the upstream add/sub stage.
REQ-006 signed_mode  input  1  high: din is two's complement; low: din is unsigned.
REQ-007 err  input  1  overflow flag from upstream; sampled together with din.
REQ-008 load  input  1  one-cycle strobe requesting conversion of din.
REQ-009 busy  output  1  high while a conversion is in progress.
REQ-010 sseg  output  8  active-low segments {dp,g,f,e,d,c,b,a}.
REQ-011 an  output  4  active-low digit enables; an[0] is the rightmost digit.

Function
REQ-012 FSM states shall be IDLE, CONV and COMMIT; busy shall be high whenever state is not IDLE.
REQ-013 load shall be accepted only in IDLE; a load while busy shall be ignored without being queued.
REQ-014 On accept, the block shall capture sign = signed_mode & din[7], magnitude = |din| as 8 bits (signed -128 gives 128), and err.
REQ-015 CONV shall run exactly 8 cycles of shift-add-3 double-dabble into hundreds, tens and ones BCD registers.
REQ-016 COMMIT shall last 1 cycle and copy the BCD, sign and err values into the display registers.
REQ-017 Display registers shall update, and busy shall fall, on the 10th rising edge after the accepting edge.
REQ-018 Digit 3 shall show '-' when sign is set, otherwise blank.
REQ-019 Digit 2 (hundreds) shall be blank when zero.
REQ-020 Digit 1 (tens) shall be blank when both it and the hundreds digit are zero.
REQ-021 Digit 0 (ones) shall always be shown.
REQ-022 The digit 0 decimal point shall be lit when the committed err is set; all other dp bits shall be off.
REQ-023 Encodings: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, '-'=BF, blank=FF (dp bit included, dp off).
REQ-024 The prescaler shall count 0 to REFRESH_DIV-1 and then wrap to 0; the scan index shall advance at the wrap, in the order 0,1,2,3,0.
REQ-025 Exactly one an bit shall be low at any time while en is high.
REQ-026 sseg shall be registered and aligned to the same cycle as an.
REQ-027 While en is low: an shall be 1111, sseg shall be FF, and the prescaler and scan index shall hold.
REQ-028 While en is low, loads shall still be accepted and conversions shall still run.
REQ-029 A display-register update during a digit's dwell shall take effect on the next clock edge with no glitch state.

Reset
REQ-030 While clr is low: an=1111, sseg=FF, busy=0, state=IDLE.
REQ-031 While clr is low: prescaler, scan index, BCD registers and display registers shall be 0/blank.
REQ-032 Asserting clr mid-conversion shall abort the conversion, with no partial commit.
REQ-033 After clr releases, the display shall stay blank until the first COMMIT.

Structure
REQ-034 Package sseg_pkg shall hold the state enum, the segment-code constants and the REFRESH_DIV default.
REQ-035 Sub-module bcd_to_sseg shall be a combinational mapping from a 4-bit code plus a blank flag to 7 segments.
REQ-036 Expected size: 150-300 lines of RTL.

Verification (benches use REFRESH_DIV=4)
REQ-037 Reset: hold clr low for 3 cycles -> an=1111, sseg=FF, busy=0 throughout.
REQ-038 Signed negative: signed_mode=1, din=F6, load, en=1 -> busy high for 10 cycles; then digits show '-', blank, '1', '0'; an steps 1110,1101,1011,0111 every 4 cycles; sseg=C0 when an=1110.
REQ-039 Unsigned with error: signed_mode=0, din=FF, err=1, load -> digits show blank, 2, 5, 5; sseg=12 (5 with dp lit) when an=1110.
REQ-040 Load while busy and signed minimum: signed_mode=1, din=80, load, then load with din=01 two cycles later -> second load ignored; digits show '-', 1, 2, 8.
REQ-041 Abort and disable: clr pulse low at cycle 5 of CONV -> blank display, busy=0, no commit; separately, en=0 -> an=1111 and the scan index holds; en=1 -> scan resumes from the same digit.
